// File: rtl/reaction_timer.sv
// Reaction-time trial: random pre-stimulus delay, LED stimulus, then millisecond measurement
// of the button response, reporting the result, a false start or a timeout.
module reaction_timer #(
    parameter int unsigned CLKS_PER_MS  = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 10,
    parameter int unsigned MAX_MS       = 9999,
    parameter int unsigned MS_W         = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            btn,
    output logic            led,
    output logic            busy,
    output logic            done,
    output logic            early,
    output logic            timeout,
    output logic [MS_W-1:0] result_ms
);
    localparam int unsigned PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int unsigned DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

    localparam logic [PRE_W-1:0] PreLast = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [DLY_W-1:0] DlyMin  = DLY_W'(MIN_DELAY_MS);
    localparam logic [DLY_W-1:0] DlyOne  = DLY_W'(1);
    localparam logic [MS_W-1:0]  MsLast  = MS_W'(MAX_MS - 1);
    localparam logic [MS_W-1:0]  MsMax   = MS_W'(MAX_MS);
    localparam logic [15:0]      LfsrSeed = 16'hACE1;
    localparam logic [15:0]      LfsrTaps = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLit,
        StResult,
        StEarly,
        StTimeout
    } state_e;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              btn_meta_q, btn_s_q, btn_dly_q;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              early_q, early_d;
    logic              timeout_q, timeout_d;
    logic [MS_W-1:0]   result_q, result_d;
    logic              tick;
    logic              btn_rise;

    // Only the synchronized rising edge counts, so a button still held from the
    // start release cannot register as a press.
    assign btn_rise = btn_s_q & ~btn_dly_q;
    assign tick     = (presc_q == PreLast);

    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        state_d   = state_q;
        delay_d   = delay_q;
        ms_d      = ms_q;
        done_d    = 1'b0;
        early_d   = early_q;
        timeout_d = timeout_q;
        result_d  = result_q;

        unique case (state_q)
            StIdle, StResult, StEarly, StTimeout: begin
                if (start) begin
                    state_d   = StWait;
                    delay_d   = DlyMin + DLY_W'(lfsr_q[RAND_BITS-1:0]);
                    presc_d   = '0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                    result_d  = '0;
                end
            end
            StWait: begin
                if (btn_rise) begin
                    state_d  = StEarly;
                    early_d  = 1'b1;
                    result_d = '0;
                    done_d   = 1'b1;
                end else if (tick) begin
                    if (delay_q == DlyOne) begin
                        state_d = StLit;
                        presc_d = '0;
                        ms_d    = '0;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end
            end
            StLit: begin
                // A press on the same cycle as the final tick still reports completed ms.
                if (btn_rise) begin
                    state_d  = StResult;
                    result_d = ms_q;
                    done_d   = 1'b1;
                end else if (tick) begin
                    if (ms_q == MsLast) begin
                        state_d   = StTimeout;
                        timeout_d = 1'b1;
                        result_d  = MsMax;
                        done_d    = 1'b1;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        led_d  = (state_d == StLit);
        busy_d = (state_d == StWait) || (state_d == StLit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            delay_q    <= '0;
            ms_q       <= '0;
            lfsr_q     <= LfsrSeed;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            btn_dly_q  <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            early_q    <= 1'b0;
            timeout_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            delay_q    <= delay_d;
            ms_q       <= ms_d;
            lfsr_q     <= lfsr_d;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            btn_dly_q  <= btn_s_q;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            early_q    <= early_d;
            timeout_q  <= timeout_d;
            result_q   <= result_d;
        end
    end

    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign early     = early_q;
    assign timeout   = timeout_q;
    assign result_ms = result_q;
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Consumer end of the start-pulse interface. It receives the single-cycle `start` pulse that the button front-end emits on button release, then runs one reaction-time trial.
- Trial sequence: wait a pseudo-random delay, light the stimulus LED, then measure the milliseconds until the next button press.
- Reports the result, a false-start flag or a timeout flag to the display logic.
- Sits between the button/start front-end and the 7-segment display driver.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick.
- MIN_DELAY_MS, 1000, fixed part of the random pre-stimulus delay.
- RAND_BITS, 10, number of LFSR bits added to the delay (0..2^RAND_BITS-1 ms).
- MAX_MS, 9999, timeout value; result saturates here.
- MS_W, 14, width of the millisecond result.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle trial-start pulse, synchronous to clk
- btn  in  1  raw button level, active-high, asynchronous
- led  out  1  stimulus LED; high only in LIT
- busy  out  1  high in WAIT or LIT
- done  out  1  one-cycle pulse on entry to RESULT, EARLY or TIMEOUT
- early  out  1  false-start flag, held until next accepted start
- timeout  out  1  no-response flag, held until next accepted start
- result_ms  out  MS_W  measured reaction time in ms, held until next accepted start

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; led=busy=done=early=timeout=0; result_ms=0.
  - Prescaler and counters = 0; sync flops = 0; LFSR = 16'hACE1.
- btn sync:
  - Two-flop synchronizer gives btn_s, plus one delay flop btn_q.
  - btn_rise = btn_s & ~btn_q.
  - Only btn_rise is used; a held button never triggers.
  - Raw btn first sampled high at edge j gives a state change at edge j+2.
- LFSR:
  - 16-bit Galois: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every cycle in every state except under reset.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1; tick=1 when it equals CLKS_PER_MS-1, then wraps to 0.
  - Cleared on every state entry into WAIT or LIT.
- States:
  - IDLE:
    - start=1 → WAIT.
    - delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], using the LFSR value in the start cycle.
    - early, timeout, result_ms cleared.
  - WAIT (busy=1):
    - btn_rise → EARLY.
    - Otherwise, on tick: if delay_cnt==1 → LIT, else decrement delay_cnt.
    - Net effect: led rises D*CLKS_PER_MS edges after the edge that accepted start, where D is the latched delay.
  - LIT (led=1, busy=1):
    - ms_cnt starts at 0 and increments on tick.
    - btn_rise → RESULT with result_ms=ms_cnt (completed ms).
    - tick when ms_cnt==MAX_MS-1 → TIMEOUT with result_ms=MAX_MS.
    - btn_rise and a timeout tick in the same cycle: btn_rise wins, result_ms=ms_cnt.
  - RESULT / EARLY / TIMEOUT:
    - Hold flags and result; led=0, busy=0.
    - EARLY sets early=1, result_ms=0. TIMEOUT sets timeout=1.
    - start=1 → WAIT, same actions as from IDLE.
  - done: registered; high for exactly the first cycle in RESULT, EARLY or TIMEOUT.
  - start in WAIT or LIT: ignored; no restart, no delay reload.
- Start/button overlap: the front-end pulses start on release, so btn_s is still 1 for up to 2 cycles after WAIT entry. This causes no btn_rise and no false EARLY.
- Widths:
  - delay_cnt is wide enough for MIN_DELAY_MS + 2^RAND_BITS-1.
  - ms_cnt is MS_W bits and never exceeds MAX_MS.
- Reset mid-operation: any state returns to IDLE immediately, led drops asynchronously, no done pulse.

Test Plan:
(Bench parameters: CLKS_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2, MAX_MS=20. The bench computes D from a Galois LFSR model.)
1. Reset check: assert rst, hold btn=0 → led=0, busy=0, done=0, early=0, timeout=0, result_ms=0. Reassert rst mid-cycle → outputs clear without waiting for clk.
2. Normal trial: 1-cycle start, btn=0.
   - busy=1 from the next edge; led=1 exactly D*4 edges after start acceptance.
   - Raise btn 7*4+1 cycles after led rises → result_ms=7, one done pulse, led=0, busy=0.
3. False start: start pulse, then btn rises 2 cycles later while in WAIT → early=1, result_ms=0, done pulse, led never asserted.
4. Timeout: start, never press → led high for 80 cycles, then timeout=1, result_ms=20, single done pulse.
5. Ignored/restart:
   - start pulses during WAIT and LIT change nothing; led timing matches scenario 2.
   - start from RESULT clears result_ms and flags, reloads the delay.
   - Held btn across the start pulse produces no EARLY.
6. Async reset in LIT → led=0, busy=0 immediately; a later start runs a full trial normally.
